// File: rtl/acorn_state_update_par.sv
// ACORN-128 state update unrolled W steps per clock, with a stream handshake
// for encrypt/decrypt words and a counted burst mode for init/finalisation.
`timescale 1ns/1ps
module acorn_state_update_par #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [292:0]     state_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     msg_in,
    input  logic             ca_in,
    input  logic             cb_in,
    input  logic             dec,
    input  logic             burst_go,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             burst_mbit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     ks_out,
    output logic [W-1:0]     dat_out,
    output logic [292:0]     state_out,
    output logic             busy,
    output logic             done
);

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32)) begin : g_bad_w
        $error("acorn_state_update_par: W must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic {IDLE, BURST} fsm_t;

    fsm_t             fsm_reg;
    logic [292:0]     state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ca_reg, cb_reg, mbit_reg;
    logic             out_valid_reg, done_reg;
    logic [W-1:0]     ks_reg, dat_reg;

    logic             in_burst, accept, step_ca, step_cb;
    logic [W-1:0]     ks_vec, dat_vec;
    logic [292:0]     state_next;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    assign in_burst = (fsm_reg == BURST);
    // A pending burst request wins over a stream word in the same cycle.
    assign in_ready = !in_burst && !load && !burst_go && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign step_ca  = in_burst ? ca_reg : ca_in;
    assign step_cb  = in_burst ? cb_reg : cb_in;

    for (genvar gi = 0; gi < W; gi++) begin : g_step
        logic [292:0] s_in, s_mid, s_out;
        logic         ks_bit, f_bit, m_bit;

        if (gi == 0) begin : g_first
            assign s_in = state_reg;
        end else begin : g_rest
            assign s_in = g_step[gi-1].s_out;
        end

        always_comb begin
            s_mid      = s_in;
            s_mid[289] = s_mid[289] ^ s_mid[235] ^ s_mid[230];
            s_mid[230] = s_mid[230] ^ s_mid[196] ^ s_mid[193];
            s_mid[193] = s_mid[193] ^ s_mid[160] ^ s_mid[154];
            s_mid[154] = s_mid[154] ^ s_mid[111] ^ s_mid[107];
            s_mid[107] = s_mid[107] ^ s_mid[66]  ^ s_mid[61];
            s_mid[61]  = s_mid[61]  ^ s_mid[23]  ^ s_mid[0];
        end

        assign ks_bit = s_mid[12] ^ s_mid[154] ^ maj(s_mid[235], s_mid[61], s_mid[193])
                      ^ ch(s_mid[230], s_mid[111], s_mid[66]);
        assign f_bit  = s_mid[0] ^ ~s_mid[107] ^ maj(s_mid[244], s_mid[23], s_mid[160])
                      ^ (step_ca & s_mid[196]) ^ (step_cb & ks_bit);
        // When decrypting, the plaintext bit feeds the state, not the ciphertext.
        assign m_bit  = in_burst ? mbit_reg : (msg_in[gi] ^ (dec & ks_bit));
        assign s_out  = {f_bit ^ m_bit, s_mid[292:1]};

        assign ks_vec[gi]  = ks_bit;
        assign dat_vec[gi] = msg_in[gi] ^ ks_bit;
    end

    assign state_next = g_step[W-1].s_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            cnt_reg       <= '0;
            ca_reg        <= 1'b0;
            cb_reg        <= 1'b0;
            mbit_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            ks_reg        <= '0;
            dat_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                state_reg <= state_in;
                fsm_reg   <= IDLE;
                cnt_reg   <= '0;
            end else begin
                case (fsm_reg)
                    IDLE: begin
                        if (burst_go) begin
                            if (burst_cnt != '0) begin
                                cnt_reg  <= burst_cnt;
                                ca_reg   <= ca_in;
                                cb_reg   <= cb_in;
                                mbit_reg <= burst_mbit;
                                fsm_reg  <= BURST;
                            end else begin
                                done_reg <= 1'b1;
                            end
                        end else if (accept) begin
                            state_reg <= state_next;
                        end
                    end
                    BURST: begin
                        state_reg <= state_next;
                        cnt_reg   <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            fsm_reg  <= IDLE;
                            done_reg <= 1'b1;
                        end
                    end
                    default: fsm_reg <= IDLE;
                endcase
            end

            if (accept) begin
                ks_reg        <= ks_vec;
                dat_reg       <= dat_vec;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign ks_out    = ks_reg;
    assign dat_out   = dat_reg;
    assign state_out = state_reg;
    assign busy      = in_burst;
    assign done      = done_reg;

endmodule

// File: doc/acorn_state_update_par.md
ACORN_STATE_UPDATE_PAR -- requirements
Module: acorn_state_update_par

Interface
REQ-001 SHALL have parameter W, default 8, meaning ACORN-128 steps per clock; legal values 1,2,4,8,16,32, others fail elaboration.
REQ-002 SHALL have parameter CNT_W, default 16, meaning burst cycle counter width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  load state_in into state register.
REQ-006 state_in  input  293  new state value (S292..S0).
REQ-007 in_valid / in_ready  input / output  1 / 1  stream-word handshake.
REQ-008 msg_in  input  W  message bits (or ciphertext when dec=1); bit i is used at step i, LSB first.
REQ-009 ca_in, cb_in, dec  input  1 each  control bits, sampled with each accepted word.
REQ-010 burst_go  input  1  start burst.
REQ-011 burst_cnt  input  CNT_W  number of burst cycles.
REQ-012 burst_mbit  input  1  message bit for all burst steps.
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 ks_out, dat_out  output  W  keystream bits; ciphertext (dec=0) or plaintext (dec=1).
REQ-015 state_out  output  293  current state register.
REQ-016 busy  output  1  burst in progress.
REQ-017 done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 One step SHALL run in this order:
- S289^=S235^S230; S230^=S196^S193; S193^=S160^S154; S154^=S111^S107; S107^=S66^S61; S61^=S23^S0.
- ks=S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66).
- f=S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks).
- Shift Sj<=Sj+1 for j=0..291; S292<=f^m.
REQ-019 The W steps of one cycle SHALL be chained combinationally, each step using the result of the previous one.
REQ-020 For stream steps, m SHALL be msg_in[i] when dec=0 and msg_in[i]^ks_i when dec=1.
REQ-021 For stream steps, dat_out[i] SHALL be msg_in[i]^ks_i.
REQ-022 FSM SHALL have states IDLE and BURST.
REQ-023 in_ready SHALL be 1 only when the FSM is in IDLE, load=0, and (out_valid=0 or out_ready=1).
REQ-024 Stream accept (in_valid&in_ready) SHALL update the state by W steps in one cycle and register ks_out/dat_out with out_valid=1 on the next edge.
REQ-025 out_valid SHALL clear on out_ready when no new word is accepted in the same cycle.
REQ-026 Under back-pressure (out_valid=1, out_ready=0), outputs SHALL hold stable and no word SHALL be accepted.
REQ-027 burst_go in IDLE with burst_cnt>0 SHALL latch burst_cnt, ca_in, cb_in and burst_mbit, and enter BURST.
REQ-028 In BURST, the block SHALL perform W steps per cycle with m=burst_mbit, decrement the counter, and leave out_valid/ks_out/dat_out untouched.
REQ-029 On the last burst cycle, the FSM SHALL return to IDLE with done=1 for that one cycle.
REQ-030 burst_go with burst_cnt=0 SHALL pulse done the next cycle and leave the state unchanged.
REQ-031 load SHALL have highest priority: in any state it writes state_in, aborts a burst without a done pulse, and goes to IDLE; out_valid is unchanged.
REQ-032 burst_go and in_valid asserted together in IDLE SHALL give the burst priority, with in_ready=0 that cycle.
REQ-033 burst_go while busy=1 SHALL be ignored.

Reset
REQ-034 rst SHALL immediately set the state register to 0, FSM to IDLE, the counter to 0, and out_valid, ks_out, dat_out, done and busy to 0.
REQ-035 in_ready SHALL be 1 after reset is released.

Verification
REQ-036 Reset, then one stream word (W=8, msg 0x00, ca=cb=dec=0) -> ks_out=0x00, dat_out=0x00, state_out bits 292..285=1 and all other bits 0.
REQ-037 Same as REQ-036 with msg 0xFF -> state_out all zero, dat_out=0xFF, ks_out=0x00.
REQ-038 Encrypt 64 random words from a loaded random state, reload the same state, decrypt with dec=1 -> plaintext returned and the final state_out identical in both runs; compare every word against a bit-serial golden model.
REQ-039 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, outputs stable, exactly one word consumed.
REQ-040 burst_cnt=3, then load asserted during the 2nd burst cycle -> state_out=state_in, no done pulse, IDLE next cycle.
REQ-041 Full burst with burst_cnt=1, and with burst_cnt=0 -> done exactly once each; with burst_cnt=1 the state advances W steps and matches the model; with burst_cnt=0 the state is unchanged.
